pipe_adder: RTL

//  Parametrised, pipelined add/subtract unit; next generation of the fixed 32-bit adders.

---
 rtl/pipe_adder_pkg.sv | 18 +
 rtl/pipe_adder_seg.sv | 26 ++
 rtl/pipe_adder.sv | 133 +++++++++++++
 3 files changed

// File: rtl/pipe_adder_pkg.sv
// Shared definitions for the pipelined add/sub unit.
// Operation encodings, stage limit and the overflow rule.
package pipe_adder_pkg;

  localparam logic ADD_OP = 1'b0;
  localparam logic SUB_OP = 1'b1;
  localparam int   MAX_STAGES = 8;

  function automatic logic ovf_f(
    input logic sg,
    input logic sb,
    input logic cm,
    input logic co
  );
    ovf_f = sg ? (cm ^ co) : (co ^ sb);
  endfunction

endpackage

// File: rtl/pipe_adder_seg.sv
// One carry-chain segment of the pipelined adder.
// cmsb is the carry into the segment MSB.
module add_seg #(
  parameter int SEG = 16
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           cin,
  output logic [SEG-1:0] sum,
  output logic           cout,
  output logic           cmsb
);

  logic [SEG:0] full;

  // segment sum with carry out and carry into MSB
  always_comb begin
    full = {1'b0, a} + {1'b0, b}
         + {{SEG{1'b0}}, cin};
    sum  = full[SEG-1:0];
    cout = full[SEG];
    cmsb = sum[SEG-1] ^ a[SEG-1]
         ^ b[SEG-1];
  end

endmodule

// File: rtl/pipe_adder.sv
// Pipelined add/sub unit, one register per carry segment.
// Valid/stall chain with bubble compression.
module pipe_adder
  import pipe_adder_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic             sub,
  input  logic             is_signed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             carry,
  output logic             overflow
);

  localparam int SEG = WIDTH / STAGES;

  logic [WIDTH-1:0] a_p  [STAGES];
  logic [WIDTH-1:0] b_p  [STAGES];
  logic             sg_p [STAGES];
  logic             sb_p [STAGES];
  logic [WIDTH-1:0] s_p  [STAGES+1];
  logic             c_p  [STAGES+1];
  logic             vp   [STAGES+1];
  logic             ld   [STAGES];
  logic [SEG-1:0]   sum_w [STAGES];
  logic             co_w [STAGES];
  logic             cm_w [STAGES];
  logic             ov_q;

  assign a_p[0]  = in0;
  assign b_p[0]  = (sub == ADD_OP) ? in1 : ~in1;
  assign sg_p[0] = is_signed;
  assign sb_p[0] = sub;
  assign s_p[0]  = '0;
  assign c_p[0]  = (sub == SUB_OP);
  assign vp[0]   = in_valid;

  // stage k loads when empty or when everything after it drains
  always_comb begin
    logic acc;
    acc = out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      acc   = acc | ~vp[k+1];
      ld[k] = acc;
    end
  end

  assign in_ready  = ld[0];
  assign out_valid = vp[STAGES];
  assign out       = s_p[STAGES];
  assign carry     = c_p[STAGES];
  assign overflow  = ov_q;

  for (genvar k = 0; k < STAGES; k++) begin : g_st
    logic [WIDTH-1:0] s_nx;
    logic             en;

    assign en = ld[k] & vp[k];

    add_seg #(
      .SEG (SEG)
    ) u_seg (
      .a    (a_p[k][k*SEG +: SEG]),
      .b    (b_p[k][k*SEG +: SEG]),
      .cin  (c_p[k]),
      .sum  (sum_w[k]),
      .cout (co_w[k]),
      .cmsb (cm_w[k])
    );

    // merge this segment into the running partial sum
    always_comb begin
      s_nx = s_p[k];
      s_nx[k*SEG +: SEG] = sum_w[k];
    end

    // stage valid, partial sum and carry
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vp[k+1]  <= 1'b0;
        s_p[k+1] <= '0;
        c_p[k+1] <= 1'b0;
      end else if (ld[k]) begin
        vp[k+1] <= vp[k];
        if (vp[k]) begin
          s_p[k+1] <= s_nx;
          c_p[k+1] <= co_w[k];
        end
      end
    end

    if (k < STAGES - 1) begin : g_fwd
      logic unused_cm;
      assign unused_cm = cm_w[k];

      // skew the operands and flags to the next segment
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_p[k+1]  <= '0;
          b_p[k+1]  <= '0;
          sg_p[k+1] <= 1'b0;
          sb_p[k+1] <= 1'b0;
        end else if (en) begin
          a_p[k+1]  <= a_p[k];
          b_p[k+1]  <= b_p[k];
          sg_p[k+1] <= sg_p[k];
          sb_p[k+1] <= sb_p[k];
        end
      end
    end else begin : g_last
      logic unused_ab;
      assign unused_ab = ^{a_p[k], b_p[k]};

      // overflow is resolved in the MSB segment
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ov_q <= 1'b0;
        else if (en)
          ov_q <= ovf_f(sg_p[k], sb_p[k],
                        cm_w[k], co_w[k]);
      end
    end
  end

endmodule
